// File: rtl/maze_pkg.sv
// Shared types and constants for the maze player controller.
package maze_pkg;

  // Wall bit positions within the {T,B,L,R} wall nibble
  localparam int unsigned WALL_T = 3;
  localparam int unsigned WALL_B = 2;
  localparam int unsigned WALL_L = 1;
  localparam int unsigned WALL_R = 0;

  // Datapath widths
  localparam int unsigned ROW_W  = 3;
  localparam int unsigned COL_W  = 4;
  localparam int unsigned DIM_W  = 5;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned LAT_W  = 2;

  typedef enum logic [1:0] {
    DIR_UP,
    DIR_DOWN,
    DIR_LEFT,
    DIR_RIGHT
  } dir_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOKUP,
    S_DECIDE,
    S_WON
  } state_e;

  // Player grid position
  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } pos_t;

endpackage

// File: rtl/btn_edge_sync.sv
// Two-flop synchroniser plus rising-edge detector for one push-button.
module btn_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  input  logic clear_i,
  output logic rise_c
);

  logic ff1_q, ff2_q, ff3_q;

  // Synchroniser chain; clear marks the current level as already seen so a
  // button held across a restart cannot produce an edge afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff1_q <= 1'b0;
      ff2_q <= 1'b0;
      ff3_q <= 1'b0;
    end else begin
      ff1_q <= btn_i;
      ff2_q <= ff1_q;
      ff3_q <= clear_i ? 1'b1 : ff2_q;
    end
  end

  assign rise_c = ff2_q & ~ff3_q;

endmodule

// File: rtl/maze_player_ctrl.sv
// Maze player movement controller: button edges -> wall-checked cell moves.
module maze_player_ctrl
  import maze_pkg::*;
#(
  parameter int unsigned START_ROW  = 0,
  parameter int unsigned START_COL  = 0,
  parameter int unsigned GOAL_ROW   = 4,
  parameter int unsigned GOAL_COL   = 9,
  parameter int unsigned LOOKUP_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             restart,
  input  logic [3:0]       walls,
  input  logic [DIM_W-1:0] num_rows,
  input  logic [DIM_W-1:0] num_cols,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] player_row,
  output logic [COL_W-1:0] player_col,
  output logic [CNT_W-1:0] move_count,
  output logic             bump,
  output logic             at_goal
);

  localparam logic [ROW_W-1:0] START_R = ROW_W'(START_ROW);
  localparam logic [COL_W-1:0] START_C = COL_W'(START_COL);
  localparam logic [ROW_W-1:0] GOAL_R  = ROW_W'(GOAL_ROW);
  localparam logic [COL_W-1:0] GOAL_C  = COL_W'(GOAL_COL);
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(LOOKUP_LAT - 1);

  logic up_rise_c, down_rise_c, left_rise_c, right_rise_c;

  state_e           state_q, state_d;
  dir_e             dir_q, dir_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;
  pos_t             pos_q, pos_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             bump_q, bump_d;
  logic             at_goal_q, at_goal_d;

  logic             blocked_c;
  pos_t             next_pos_c;

  btn_edge_sync u_sync_up (
    .clk(clk), .rst_n(rst_n), .btn_i(btn_up), .clear_i(restart), .rise_c(up_rise_c)
  );
  btn_edge_sync u_sync_down (
    .clk(clk), .rst_n(rst_n), .btn_i(btn_down), .clear_i(restart), .rise_c(down_rise_c)
  );
  btn_edge_sync u_sync_left (
    .clk(clk), .rst_n(rst_n), .btn_i(btn_left), .clear_i(restart), .rise_c(left_rise_c)
  );
  btn_edge_sync u_sync_right (
    .clk(clk), .rst_n(rst_n), .btn_i(btn_right), .clear_i(restart), .rise_c(right_rise_c)
  );

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      dir_q     <= DIR_UP;
      cnt_q     <= '0;
      pos_q     <= '{row: START_R, col: START_C};
      count_q   <= '0;
      bump_q    <= 1'b0;
      at_goal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      cnt_q     <= cnt_d;
      pos_q     <= pos_d;
      count_q   <= count_d;
      bump_q    <= bump_d;
      at_goal_q <= at_goal_d;
    end
  end

  // Wall / grid-edge check for the latched direction at the current cell
  always_comb begin
    blocked_c  = 1'b0;
    next_pos_c = pos_q;
    unique case (dir_q)
      DIR_UP: begin
        blocked_c      = walls[WALL_T] || (pos_q.row == '0);
        next_pos_c.row = pos_q.row - ROW_W'(1);
      end
      DIR_DOWN: begin
        blocked_c      = walls[WALL_B] ||
                         ((DIM_W'(pos_q.row) + DIM_W'(1)) >= num_rows);
        next_pos_c.row = pos_q.row + ROW_W'(1);
      end
      DIR_LEFT: begin
        blocked_c      = walls[WALL_L] || (pos_q.col == '0);
        next_pos_c.col = pos_q.col - COL_W'(1);
      end
      DIR_RIGHT: begin
        blocked_c      = walls[WALL_R] ||
                         ((DIM_W'(pos_q.col) + DIM_W'(1)) >= num_cols);
        next_pos_c.col = pos_q.col + COL_W'(1);
      end
      default: begin
        blocked_c = 1'b1;
      end
    endcase
  end

  // Next-state and register updates
  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    cnt_d     = cnt_q;
    pos_d     = pos_q;
    count_d   = count_q;
    bump_d    = 1'b0;

    if (restart) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      pos_d   = '{row: START_R, col: START_C};
      count_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (up_rise_c || down_rise_c || left_rise_c || right_rise_c) begin
            if (up_rise_c)        dir_d = DIR_UP;
            else if (down_rise_c) dir_d = DIR_DOWN;
            else if (left_rise_c) dir_d = DIR_LEFT;
            else                  dir_d = DIR_RIGHT;
            cnt_d   = LAT_INIT;
            state_d = S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (cnt_q == '0) state_d = S_DECIDE;
          else             cnt_d   = cnt_q - LAT_W'(1);
        end
        S_DECIDE: begin
          if (blocked_c) begin
            bump_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            pos_d   = next_pos_c;
            count_d = (count_q == '1) ? count_q : count_q + CNT_W'(1);
            state_d = (next_pos_c.row == GOAL_R && next_pos_c.col == GOAL_C)
                      ? S_WON : S_IDLE;
          end
        end
        S_WON: begin
          state_d = S_WON;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    at_goal_d = (state_d == S_WON);
  end

  assign row        = pos_q.row;
  assign col        = pos_q.col;
  assign player_row = pos_q.row;
  assign player_col = pos_q.col;
  assign move_count = count_q;
  assign bump       = bump_q;
  assign at_goal    = at_goal_q;

endmodule

// File: tb/tb_maze_player_ctrl.sv
// Directed self-checking bench for maze_player_ctrl (default parameters).
module tb_maze_player_ctrl;

  logic        clk;
  logic        rst_n;
  logic [3:0]  btns;      // {up, down, left, right}
  logic        restart;
  logic [3:0]  walls;
  logic [4:0]  num_rows;
  logic [4:0]  num_cols;
  logic [2:0]  row;
  logic [3:0]  col;
  logic [2:0]  player_row;
  logic [3:0]  player_col;
  logic [15:0] move_count;
  logic        bump;
  logic        at_goal;

  int n_total;
  int n_bad;

  localparam logic [3:0] B_UP    = 4'b1000;
  localparam logic [3:0] B_DOWN  = 4'b0100;
  localparam logic [3:0] B_LEFT  = 4'b0010;
  localparam logic [3:0] B_RIGHT = 4'b0001;

  maze_player_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_up     (btns[3]),
    .btn_down   (btns[2]),
    .btn_left   (btns[1]),
    .btn_right  (btns[0]),
    .restart    (restart),
    .walls      (walls),
    .num_rows   (num_rows),
    .num_cols   (num_cols),
    .row        (row),
    .col        (col),
    .player_row (player_row),
    .player_col (player_col),
    .move_count (move_count),
    .bump       (bump),
    .at_goal    (at_goal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_pos(input string tag, input logic [2:0] er, input logic [3:0] ec,
                         input logic [15:0] en);
    chk({tag, "_row"}, 32'(player_row), 32'(er));
    chk({tag, "_col"}, 32'(player_col), 32'(ec));
    chk({tag, "_cnt"}, 32'(move_count), 32'(en));
    chk({tag, "_qrow"}, 32'(row), 32'(er));
    chk({tag, "_qcol"}, 32'(col), 32'(ec));
  endtask

  // Press a button pattern at edge t, check at t+3, t+4 (result) and t+5
  task automatic do_move(input string tag, input logic [3:0] mask, input logic [3:0] w,
                         input logic [2:0] er, input logic [3:0] ec, input logic [15:0] en,
                         input logic eb, input logic eg);
    walls = w;
    tick();
    tick();
    btns = mask;
    tick();            // t
    tick();            // t+1
    tick();            // t+2
    btns = 4'b0000;
    tick();            // t+3
    chk({tag, "_early_bump"}, 32'(bump), 32'(0));
    tick();            // t+4
    chk_pos(tag, er, ec, en);
    chk({tag, "_bump"}, 32'(bump), 32'(eb));
    chk({tag, "_goal"}, 32'(at_goal), 32'(eg));
    tick();            // t+5
    chk({tag, "_bump_pulse"}, 32'(bump), 32'(0));
  endtask

  initial begin
    n_total  = 0;
    n_bad    = 0;
    rst_n    = 1'b0;
    btns     = 4'b0000;
    restart  = 1'b0;
    walls    = 4'b0000;
    num_rows = 5'd5;
    num_cols = 5'd10;

    tick();
    tick();
    chk_pos("rst_hold", 3'd0, 4'd0, 16'd0);
    chk("rst_hold_bump", 32'(bump), 32'(0));
    chk("rst_hold_goal", 32'(at_goal), 32'(0));
    rst_n = 1'b1;
    tick();
    chk_pos("rst_rel", 3'd0, 4'd0, 16'd0);

    // Left at (0,0): wall and grid edge both block
    do_move("left_edge", B_LEFT, 4'b1110, 3'd0, 4'd0, 16'd0, 1'b1, 1'b0);
    // Right with R open
    do_move("right1", B_RIGHT, 4'b1110, 3'd0, 4'd1, 16'd1, 1'b0, 1'b0);
    // Walk right to column 9
    for (int i = 2; i <= 9; i++)
      do_move($sformatf("walk_r%0d", i), B_RIGHT, 4'b0000, 3'd0, 4'(i), 16'(i), 1'b0, 1'b0);
    // Right at column 9: grid edge only
    do_move("right_grid", B_RIGHT, 4'b0000, 3'd0, 4'd9, 16'd9, 1'b1, 1'b0);
    // Up at row 0: grid edge only
    do_move("up_grid", B_UP, 4'b0000, 3'd0, 4'd9, 16'd9, 1'b1, 1'b0);
    // Down with bottom wall
    do_move("down_wall", B_DOWN, 4'b0100, 3'd0, 4'd9, 16'd9, 1'b1, 1'b0);
    do_move("down1", B_DOWN, 4'b0000, 3'd1, 4'd9, 16'd10, 1'b0, 1'b0);
    // Up and right together: up wins
    do_move("up_right", B_UP | B_RIGHT, 4'b0000, 3'd0, 4'd9, 16'd11, 1'b0, 1'b0);

    // Hold down for 20 cycles; a left press during LOOKUP is dropped
    walls = 4'b0000;
    tick();
    tick();
    btns = B_DOWN;
    tick();                      // t
    btns = B_DOWN | B_LEFT;
    tick();                      // t+1
    tick();                      // t+2
    btns = B_DOWN;
    for (int i = 3; i < 20; i++) tick();
    chk_pos("hold", 3'd1, 4'd9, 16'd12);
    chk("hold_bump", 32'(bump), 32'(0));
    btns = 4'b0000;
    tick();
    tick();
    tick();

    // Path to the goal
    do_move("to_r2", B_DOWN, 4'b0000, 3'd2, 4'd9, 16'd13, 1'b0, 1'b0);
    do_move("to_r3", B_DOWN, 4'b0000, 3'd3, 4'd9, 16'd14, 1'b0, 1'b0);
    do_move("to_goal", B_DOWN, 4'b0000, 3'd4, 4'd9, 16'd15, 1'b0, 1'b1);
    // Presses ignored once won
    do_move("won_up", B_UP, 4'b0000, 3'd4, 4'd9, 16'd15, 1'b0, 1'b1);
    do_move("won_left", B_LEFT, 4'b0000, 3'd4, 4'd9, 16'd15, 1'b0, 1'b1);

    // Restart returns to start
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk_pos("restart", 3'd0, 4'd0, 16'd0);
    chk("restart_goal", 32'(at_goal), 32'(0));
    chk("restart_bump", 32'(bump), 32'(0));

    // Single-row grid: down blocked by row+1 >= num_rows
    num_rows = 5'd1;
    do_move("down_1row", B_DOWN, 4'b0000, 3'd0, 4'd0, 16'd0, 1'b1, 1'b0);
    num_rows = 5'd5;

    // Async reset during LOOKUP abandons the move
    walls = 4'b0000;
    tick();
    tick();
    btns = B_RIGHT;
    tick();                      // t
    tick();                      // t+1
    tick();                      // t+2, LOOKUP
    btns = 4'b0000;
    rst_n = 1'b0;
    #1;
    chk_pos("mid_rst", 3'd0, 4'd0, 16'd0);
    chk("mid_rst_bump", 32'(bump), 32'(0));
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk_pos("post_rst", 3'd0, 4'd0, 16'd0);
    chk("post_rst_bump", 32'(bump), 32'(0));

    // Controller still works after the reset
    do_move("after_rst", B_RIGHT, 4'b0000, 3'd0, 4'd1, 16'd1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/maze_player_ctrl.md
# maze_player_ctrl

Player movement controller sitting directly downstream of the maze level ROMs (level1..level3). It turns four push-buttons into single-cell moves and presents the player's current cell as the ROM lookup address. It then reads back the cell's wall bits and the level's grid size, and commits a move only if no wall or grid edge blocks it. It outputs the player position, a move counter, and bump/goal indications to the renderer and score logic.

## Interface
- `START_ROW`, 0: reset/restart row of the player.
- `START_COL`, 0: reset/restart column of the player.
- `GOAL_ROW`, 4: goal cell row.
- `GOAL_COL`, 9: goal cell column.
- `LOOKUP_LAT`, 1: cycles to wait after the query address is stable before sampling `walls`; range 1..3.
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`  in  1 each  raw push-buttons, asynchronous to `clk`.
- `restart`  in  1  synchronous, clk-domain pulse; returns the player to start.
- `walls`  in  4  from the level ROM; order {T,B,L,R}, 1 = wall present.
- `num_rows`  in  5  from the level ROM; grid height.
- `num_cols`  in  5  from the level ROM; grid width.
- `row`  out  3  ROM query row; always equals `player_row`.
- `col`  out  4  ROM query column; always equals `player_col` (4 bits to reach column 9).
- `player_row`  out  3  current row.
- `player_col`  out  4  current column.
- `move_count`  out  16  committed moves; saturating.
- `bump`  out  1  one-cycle pulse when a move is rejected.
- `at_goal`  out  1  high while in WON.

## Operation
- Each button passes through a 2-FF synchroniser, then a rising-edge detector (FF2 & ~FF3). Only rising edges count; holding a button gives one move.
- Simultaneous edges in the same cycle: priority is up > down > left > right. Lower-priority edges are discarded.
- FSM states:
  - IDLE: on any edge, latch the direction and go to LOOKUP.
  - LOOKUP: count down LOOKUP_LAT cycles, then go to DECIDE.
  - DECIDE: sample `walls`, `num_rows` and `num_cols`, then commit or reject, then return to IDLE or go to WON.
  - WON: ignore all button edges.
- Edges arriving in LOOKUP, DECIDE or WON are dropped. There is no queueing.
- Blocking rules in DECIDE:
  - up is blocked if T=1 or row==0.
  - down is blocked if B=1 or row+1 >= num_rows.
  - left is blocked if L=1 or col==0.
  - right is blocked if R=1 or col+1 >= num_cols.
  - Bound compares are done at 5 bits, zero-extended.
- On a commit: update the position and increment `move_count`, saturating at 16'hFFFF.
- On a reject: pulse `bump` for one cycle. Position and count are unchanged.
- If a committed move lands on (GOAL_ROW, GOAL_COL), go to WON; `at_goal` is registered high there.
- `restart` has priority over everything, in any state. On the next edge it sets position = start, `move_count` = 0, state = IDLE, `at_goal` = 0, `bump` = 0, and clears the edge-detector history FFs so that a held button does not fire.
- Reset values: `player_row` = START_ROW, `player_col` = START_COL, `move_count` = 0, `bump` = 0, `at_goal` = 0, state IDLE, and all synchroniser FFs at 0.
- An asynchronous reset asserted mid-move abandons the move; nothing partial is committed.

## Timing
- All outputs are registered except `row`/`col`, which are wires equal to the position registers.
- Latency: a button first sampled high at edge t gives FF2 high at t+1, the edge seen in IDLE during the following cycle, LOOKUP from t+2, DECIDE at t+2+LOOKUP_LAT, and the new position at t+3+LOOKUP_LAT.
  - With LOOKUP_LAT=1 this is 4 edges.
- `bump` is high on the same edge a commit would have updated the position.
- Minimum spacing between accepted moves is 2+LOOKUP_LAT cycles.
- The ROM address is unchanged throughout LOOKUP/DECIDE, so the sampled `walls` always belong to the current cell.

## Structure
- A shared package `maze_pkg` holds:
  - wall bit indices WALL_T=3, WALL_B=2, WALL_L=1, WALL_R=0;
  - a direction enum {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT};
  - an FSM state enum {S_IDLE, S_LOOKUP, S_DECIDE, S_WON}.
- One sub-module `btn_edge_sync` (2-FF sync + edge detect + clear input), instantiated four times.
- Everything else lives in `maze_player_ctrl`.

## Test plan
- Reset, then press right, with `walls`=4'b1110 (R open) and num_cols=10 -> after 4 cycles `player_col`=1, `move_count`=1, no `bump`.
- At (0,0), press left with `walls`=4'b1110 -> `bump` pulses once at edge t+4; position (0,0) and `move_count`=0 are unchanged.
- At col 9, press right with `walls`=4'b0000 (grid-edge case) -> `bump`, no move.
- Assert up and right edges in the same cycle, with T open and R open at row 1 -> only up is taken; `player_row` decrements and `move_count` increments by 1.
- Hold `btn_down` high for 20 cycles -> exactly one move; a second press issued during LOOKUP is dropped.
- Drive a path to (4,9) -> `at_goal`=1 and further presses are ignored; `restart` -> position (0,0), `move_count`=0, `at_goal`=0 on the next edge.
- Assert `rst_n` low during LOOKUP -> outputs return to their reset values immediately, and no move is committed after release.
